aes_share_encoder: RTL and testbench
====================================

# aes_share_encoder

Input-side masking front end for the masked AES core. It accepts an unmasked 128-bit plaintext and a 256-bit key as a stream of 32-bit words. Each word is split into `d` Boolean shares using an internal reseedable PRNG. The complete sharing is presented to the core's `in_shares_plaintext` / `in_shares_key` valid/ready port. It is the encoding counterpart of the output recombination path.

## Interface
- `d`, 2, number of shares (≥2)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-low
- `in_word`  in  32  unmasked data word; `in_word[8k+7:8k]` = byte 4n+k of word n
- `in_word_valid` / `in_word_ready`  in/out  1  word handshake
- `in_key_reuse`  in  1  sampled with word 0; only present with `SHARE_ENC_KEY_REUSE_EN`
- `in_seed`  in  80  PRNG seed
- `in_seed_valid` / `in_seed_ready`  in/out  1  seed handshake
- `out_shares_plaintext`  out  128*d  share i at `[128*i +: 128]`
- `out_shares_key`  out  256*d  share i at `[256*i +: 256]`
- `out_valid` / `out_ready`  out/in  1  output handshake

## Operation
- PRNG: 80-bit Fibonacci LFSR, taps x^80+x^79+x^43+x^42+1, unrolled to 32 steps/cycle. Each step yields one 32-bit chunk `r`, taken from the low 32 state bits before the advance.
- A seed of all zeros is loaded as 80'h1.
- Word order: words 0–3 are plaintext, mapped to share bits `[32n +: 32]`. Words 4–11 are key, mapped to `[32(n-4) +: 32]`.
- Masking: shares 1..d-1 take one fresh `r` each, in increasing share index. Share 0 = word ⊕ r1 ⊕ … ⊕ r(d-1).
- States:
  - UNSEEDED: only the seed handshake is active. Seed accept → LOAD.
  - LOAD: `in_word_ready=1`. Word accept → MASK.
  - MASK: d-1 cycles, one chunk per cycle. On the last cycle share 0 is written. Then go to OUT if 12 words have been taken (4 under key reuse), else LOAD.
  - OUT: `out_valid=1`. On `out_ready` → LOAD and clear the word counter.
- `in_seed_ready=1` only in UNSEEDED, or in LOAD with word counter 0. A seed accept replaces the LFSR state in that cycle.
- If seed valid and word valid are both asserted in LOAD with counter 0, the seed wins and the word waits one cycle.
- Reset at any point clears the counter and all share registers and returns to UNSEEDED. Any partial input is discarded.
- There is no double buffering. The next input is accepted only after the output handshake completes.

## Timing
- Reset values: `in_word_ready=0`, `in_seed_ready=1`, `out_valid=0`, all share outputs 0.
- Throughput: d cycles per word (1 accept cycle + d-1 mask cycles).
- From the word-0 accept to `out_valid` rise: 12·d cycles. With key reuse: 4·d cycles.
- `out_valid` and the shares stay stable until `out_ready` is sampled high. There is no combinational path from `out_ready` to `out_valid`.
- LFSR advances only in MASK cycles.

## Configuration
- `SHARE_ENC_KEY_REUSE_EN`
  - Defined: if `in_key_reuse=1` on the word-0 accept, only 4 plaintext words are taken. The key share registers keep their previous contents, which are not remasked. Before any key has been loaded since reset, they are zero.
  - Undefined: the `in_key_reuse` port is absent and every input is exactly 12 words.

## Structure
- Shared package `aes_share_pkg`:
  - LFSR width and tap constants
  - words-per-block constants (4, 12)
  - FSM state encoding
- One sub-module `share_prng_lfsr80`: seed load, zero-seed fixup, 32-bit-per-cycle advance with enable.
- The top level holds the FSM, word counter and share registers.

## Test plan
- Seed not yet loaded, `in_word_valid=1` for 20 cycles → `in_word_ready` stays 0. Then seed 80'h1 is accepted one cycle after `in_seed_valid`.
- d=2, seed 80'h0123456789ABCDEF0123: feed the FIPS-197 C.3 plaintext 00112233…eeff and key 000102…1f → `out_valid` exactly 24 cycles after the word-0 accept. XOR of the shares equals the unmasked input, and share 1 equals the golden LFSR stream.
- d=3, same vectors: 36-cycle latency. Hold `out_ready=0` for 50 cycles → outputs stable, `in_word_ready=0`.
- Seed valid and word valid asserted together in LOAD, counter 0 → seed accepted first, word accepted the next cycle. Seed 0 → same stream as seed 1.
- Reset asserted after word 7 → all outputs 0, state UNSEEDED. After reseed with the same seed, a fresh 12-word input gives output identical to the run with no reset.
- With `SHARE_ENC_KEY_REUSE_EN`: run a full input, then a 4-word input with `in_key_reuse=1` → latency 4·d cycles, key shares bit-identical to the previous output, plaintext shares recombine correctly.

Source files
------------

// File: rtl/aes_share_pkg.sv
// Shared definitions for the AES input share encoder: PRNG geometry,
// block word counts, FSM state encoding and the 32-step LFSR advance.
package aes_share_pkg;

    localparam int unsigned LFSR_W          = 80;
    localparam int unsigned CHUNK_W         = 32;
    localparam int unsigned STEPS_PER_CYCLE = 32;

    // Feedback taps for x^80 + x^79 + x^43 + x^42 + 1 (zero-based bit indices)
    localparam int unsigned LFSR_TAP0 = 79;
    localparam int unsigned LFSR_TAP1 = 78;
    localparam int unsigned LFSR_TAP2 = 42;
    localparam int unsigned LFSR_TAP3 = 41;

    // An all-zero seed would lock the LFSR; it is replaced by this value
    localparam logic [LFSR_W-1:0] LFSR_ZERO_FIX = 80'h1;

    localparam int unsigned WORDS_PT   = 4;
    localparam int unsigned WORDS_FULL = 12;

    typedef enum logic [1:0] {
        ST_UNSEEDED,
        ST_LOAD,
        ST_MASK,
        ST_OUT
    } enc_state_t;

    // Fibonacci LFSR: shift left, feedback enters at bit 0; unrolled 32 steps
    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] t;
        t = s;
        for (int unsigned i = 0; i < STEPS_PER_CYCLE; i++) begin
            t = {t[LFSR_W-2:0], t[LFSR_TAP0] ^ t[LFSR_TAP1] ^ t[LFSR_TAP2] ^ t[LFSR_TAP3]};
        end
        return t;
    endfunction

endpackage

// File: rtl/aes_share_encoder_prng.sv
// 80-bit reseedable mask PRNG: one 32-bit chunk per enabled cycle, taken
// from the low state bits before the advance.
module share_prng_lfsr80
    import aes_share_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [LFSR_W-1:0]  i_seed,
    input  logic               i_load,
    input  logic               i_adv,
    output logic [CHUNK_W-1:0] o_chunk
);

    logic [LFSR_W-1:0] r_lfsr;

    // Seed load has priority over advance; zero seed is fixed up
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr <= LFSR_ZERO_FIX;
        end else if (i_load) begin
            r_lfsr <= (i_seed == '0) ? LFSR_ZERO_FIX : i_seed;
        end else if (i_adv) begin
            r_lfsr <= lfsr_advance(r_lfsr);
        end
    end

    assign o_chunk = r_lfsr[CHUNK_W-1:0];

endmodule

// File: rtl/aes_share_encoder.sv
// Input-side masking front end: splits a 128-bit plaintext and 256-bit key,
// delivered as 32-bit words, into d Boolean shares.
// Optional feature macro: SHARE_ENC_KEY_REUSE_EN (plaintext-only block that
// keeps the previous key shares).
module aes_share_encoder
    import aes_share_pkg::*;
#(
    parameter int unsigned d = 2
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        in_word,
    input  logic               in_word_valid,
    output logic               in_word_ready,
`ifdef SHARE_ENC_KEY_REUSE_EN
    input  logic               in_key_reuse,
`endif
    input  logic [79:0]        in_seed,
    input  logic               in_seed_valid,
    output logic               in_seed_ready,
    output logic [128*d-1:0]   out_shares_plaintext,
    output logic [256*d-1:0]   out_shares_key,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned MW = $clog2(d);

    enc_state_t                 r_state;
    logic [3:0]                 r_cnt;
    logic [MW-1:0]              r_mcnt;
    logic [31:0]                r_acc;
    logic [d-1:0][3:0][31:0]    r_pt;
    logic [d-1:0][7:0][31:0]    r_key;
    logic                       r_out_valid;
`ifdef SHARE_ENC_KEY_REUSE_EN
    logic                       r_reuse;
`endif

    logic                       w_seed_ready;
    logic                       w_seed_acc;
    logic                       w_word_acc;
    logic                       w_adv;
    logic [31:0]                w_chunk;
    logic                       w_last_mask;
    logic                       w_last_word;
    logic                       w_is_key;
    logic [2:0]                 w_key_idx;

    assign w_seed_ready  = (r_state == ST_UNSEEDED) || ((r_state == ST_LOAD) && (r_cnt == '0));
    assign in_seed_ready = w_seed_ready;
    // A pending seed at the block boundary takes the cycle; the word waits
    assign in_word_ready = (r_state == ST_LOAD) && !((r_cnt == '0) && in_seed_valid);
    assign w_seed_acc    = in_seed_valid && w_seed_ready;
    assign w_word_acc    = in_word_valid && in_word_ready;
    assign w_adv         = (r_state == ST_MASK);
    assign w_last_mask   = (r_mcnt == MW'(d - 1));
    assign w_is_key      = (r_cnt >= 4'(WORDS_PT));
    assign w_key_idx     = 3'(r_cnt - 4'(WORDS_PT));
`ifdef SHARE_ENC_KEY_REUSE_EN
    assign w_last_word   = r_reuse ? (r_cnt == 4'(WORDS_PT - 1)) : (r_cnt == 4'(WORDS_FULL - 1));
`else
    assign w_last_word   = (r_cnt == 4'(WORDS_FULL - 1));
`endif

    share_prng_lfsr80 u_prng (
        .clk     (clk),
        .rst     (rst),
        .i_seed  (in_seed),
        .i_load  (w_seed_acc),
        .i_adv   (w_adv),
        .o_chunk (w_chunk)
    );

    // Block FSM: accept word, mask shares 1..d-1 one per cycle, share 0 last
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_UNSEEDED;
            r_cnt       <= '0;
            r_mcnt      <= '0;
            r_acc       <= '0;
            r_pt        <= '0;
            r_key       <= '0;
            r_out_valid <= 1'b0;
`ifdef SHARE_ENC_KEY_REUSE_EN
            r_reuse     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_UNSEEDED: begin
                    if (w_seed_acc) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_word_acc) begin
                        r_acc   <= in_word;
                        r_mcnt  <= MW'(1);
                        r_state <= ST_MASK;
`ifdef SHARE_ENC_KEY_REUSE_EN
                        if (r_cnt == '0) begin
                            r_reuse <= in_key_reuse;
                        end
`endif
                    end
                end
                ST_MASK: begin
                    if (w_is_key) begin
                        r_key[r_mcnt][w_key_idx] <= w_chunk;
                    end else begin
                        r_pt[r_mcnt][r_cnt[1:0]] <= w_chunk;
                    end
                    r_acc <= r_acc ^ w_chunk;
                    if (w_last_mask) begin
                        if (w_is_key) begin
                            r_key[0][w_key_idx] <= r_acc ^ w_chunk;
                        end else begin
                            r_pt[0][r_cnt[1:0]] <= r_acc ^ w_chunk;
                        end
                        r_cnt <= r_cnt + 4'd1;
                        if (w_last_word) begin
                            r_state     <= ST_OUT;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end else begin
                        r_mcnt <= r_mcnt + MW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state     <= ST_LOAD;
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_state <= ST_UNSEEDED;
                end
            endcase
        end
    end

    assign out_shares_plaintext = r_pt;
    assign out_shares_key       = r_key;
    assign out_valid            = r_out_valid;

endmodule

// File: tb/tb_aes_share_encoder.sv
// Directed bench for aes_share_encoder with d=2 and d=3 instances sharing inputs.
module tb_aes_share_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] in_word;
    logic        in_word_valid;
    logic [79:0] in_seed;
    logic        in_seed_valid;
    logic        out_ready;
`ifdef SHARE_ENC_KEY_REUSE_EN
    logic        in_key_reuse;
`endif

    logic         w2_wr, w2_sr, w2_ov;
    logic [255:0] w2_pt;
    logic [511:0] w2_key;
    logic         w3_wr, w3_sr, w3_ov;
    logic [383:0] w3_pt;
    logic [767:0] w3_key;

    aes_share_encoder #(.d(2)) u_dut2 (
        .clk                  (clk),
        .rst                  (rst),
        .in_word              (in_word),
        .in_word_valid        (in_word_valid),
        .in_word_ready        (w2_wr),
`ifdef SHARE_ENC_KEY_REUSE_EN
        .in_key_reuse         (in_key_reuse),
`endif
        .in_seed              (in_seed),
        .in_seed_valid        (in_seed_valid),
        .in_seed_ready        (w2_sr),
        .out_shares_plaintext (w2_pt),
        .out_shares_key       (w2_key),
        .out_valid            (w2_ov),
        .out_ready            (out_ready)
    );

    aes_share_encoder #(.d(3)) u_dut3 (
        .clk                  (clk),
        .rst                  (rst),
        .in_word              (in_word),
        .in_word_valid        (in_word_valid),
        .in_word_ready        (w3_wr),
`ifdef SHARE_ENC_KEY_REUSE_EN
        .in_key_reuse         (in_key_reuse),
`endif
        .in_seed              (in_seed),
        .in_seed_valid        (in_seed_valid),
        .in_seed_ready        (w3_sr),
        .out_shares_plaintext (w3_pt),
        .out_shares_key       (w3_key),
        .out_valid            (w3_ov),
        .out_ready            (out_ready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int dsel = 2;
    int acc_cyc = 0;
    int first_wait = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;
    vec_t vec [12];

    bit q [0:1199];

    logic [255:0] snap_pt;
    logic [511:0] snap_key;
    logic [383:0] s3_pt;
    logic [767:0] s3_key;

    localparam logic [79:0] SEED_A = 80'h0123456789ABCDEF0123;

    function automatic logic wr();
        return (dsel == 2) ? w2_wr : w3_wr;
    endfunction
    function automatic logic sr();
        return (dsel == 2) ? w2_sr : w3_sr;
    endfunction
    function automatic logic ov();
        return (dsel == 2) ? w2_ov : w3_ov;
    endfunction

    function automatic logic [31:0] sh(input int j, input int n);
        if (dsel == 2)
            return (n < 4) ? w2_pt[128*j + 32*n +: 32] : w2_key[256*j + 32*(n-4) +: 32];
        else
            return (n < 4) ? w3_pt[128*j + 32*n +: 32] : w3_key[256*j + 32*(n-4) +: 32];
    endfunction

    // Generated-bit sequence of the LFSR: q[j] holds x_(j-79);
    // x_t = x_(t-80) ^ x_(t-79) ^ x_(t-43) ^ x_(t-42), state bit i at time t = x_(t-i)
    task automatic gen_q(input logic [79:0] seed);
        logic [79:0] s;
        s = (seed == '0) ? 80'h1 : seed;
        for (int i = 0; i < 80; i++) q[79-i] = s[i];
        for (int t = 1; t <= 1120; t++) q[t+79] = q[t-1] ^ q[t] ^ q[t+36] ^ q[t+37];
    endtask

    function automatic logic [31:0] chunk(input int k);
        logic [31:0] c;
        for (int i = 0; i < 32; i++) c[i] = q[32*k - i + 79];
        return c;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_word_valid = 1'b0;
        in_seed_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send_seed(input logic [79:0] s);
        int w;
        bit ok;
        in_seed = s;
        in_seed_valid = 1'b1;
        w = 0;
        ok = 0;
        while (!ok && w < 100) begin
            @(negedge clk);
            w++;
            ok = sr();
        end
        if (!ok) chk("seed_timeout", 0, 1);
        @(posedge clk);
        #1 in_seed_valid = 1'b0;
    endtask

    task automatic send_block(input int n, input logic [31:0] xm);
        int w;
        bit ok;
        for (int i = 0; i < n; i++) begin
            in_word = vec[i].word ^ ((i < 4) ? xm : 32'h0);
            in_word_valid = 1'b1;
            w = 0;
            ok = 0;
            while (!ok && w < 100) begin
                @(negedge clk);
                w++;
                ok = wr();
            end
            if (!ok) begin
                chk($sformatf("word%0d_timeout", i), 0, 1);
                break;
            end
            if (i == 0) begin
                acc_cyc = cyc;
                first_wait = w;
            end
            @(posedge clk);
            #1;
        end
        in_word_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input int exp_lat);
        int w;
        bit ok;
        w = 0;
        ok = 0;
        while (!ok && w < 500) begin
            @(negedge clk);
            w++;
            ok = ov();
        end
        chk(nm, ok ? (cyc - acc_cyc) : -1, exp_lat);
    endtask

    task automatic check_shares(input int nw, input logic [31:0] xm, input int base, input string tag);
        logic [31:0] x;
        for (int n = 0; n < nw; n++) begin
            x = '0;
            for (int j = 0; j < dsel; j++) x ^= sh(j, n);
            chk($sformatf("%s_recomb%0d", tag, n), x, vec[n].exp ^ ((n < 4) ? xm : 32'h0));
            for (int j = 1; j < dsel; j++)
                chk($sformatf("%s_sh%0d_w%0d", tag, j, n), sh(j, n), chunk(base + n*(dsel-1) + j - 1));
        end
    endtask

    task automatic complete_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("ov_clear", ov(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int errw;
        // FIPS-197 C.3 plaintext and 256-bit key, byte 4n+k in word n bits [8k+7:8k]
        vec[0]  = '{32'h33221100, 32'h33221100};
        vec[1]  = '{32'h77665544, 32'h77665544};
        vec[2]  = '{32'hbbaa9988, 32'hbbaa9988};
        vec[3]  = '{32'hffeeddcc, 32'hffeeddcc};
        vec[4]  = '{32'h03020100, 32'h03020100};
        vec[5]  = '{32'h07060504, 32'h07060504};
        vec[6]  = '{32'h0b0a0908, 32'h0b0a0908};
        vec[7]  = '{32'h0f0e0d0c, 32'h0f0e0d0c};
        vec[8]  = '{32'h13121110, 32'h13121110};
        vec[9]  = '{32'h17161514, 32'h17161514};
        vec[10] = '{32'h1b1a1918, 32'h1b1a1918};
        vec[11] = '{32'h1f1e1d1c, 32'h1f1e1d1c};

        in_word = '0;
        in_seed = '0;
`ifdef SHARE_ENC_KEY_REUSE_EN
        in_key_reuse = 1'b0;
`endif

        // Reset state and unseeded behaviour
        dsel = 2;
        do_reset();
        @(negedge clk);
        chk("rst_wready", wr(), 0);
        chk("rst_sready", sr(), 1);
        chk("rst_ov", ov(), 0);
        chk("rst_pt", w2_pt, 0);
        chk("rst_key", w2_key, 0);
        in_word_valid = 1'b1;
        errw = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr()) errw++;
        end
        chk("unseeded_wready", errw, 0);
        in_word_valid = 1'b0;
        @(posedge clk);
        #1 in_seed = 80'h1;
        in_seed_valid = 1'b1;
        @(negedge clk);
        chk("seed1_ready", sr(), 1);
        @(posedge clk);
        #1 in_seed_valid = 1'b0;
        @(negedge clk);
        chk("seed1_load", {sr(), wr()}, 2'b11);

        // d=2 full block
        dsel = 2;
        do_reset();
        gen_q(SEED_A);
        send_seed(SEED_A);
        send_block(12, 32'h0);
        wait_out("lat_d2", 24);
        check_shares(12, 32'h0, 0, "d2");
        snap_pt = w2_pt;
        snap_key = w2_key;
        complete_out();

        // d=3 full block and output stall
        dsel = 3;
        do_reset();
        send_seed(SEED_A);
        send_block(12, 32'h0);
        wait_out("lat_d3", 36);
        check_shares(12, 32'h0, 0, "d3");
        s3_pt = w3_pt;
        s3_key = w3_key;
        in_word_valid = 1'b1;
        errs = 0;
        errw = 0;
        repeat (50) begin
            @(negedge clk);
            if (!w3_ov || w3_pt !== s3_pt || w3_key !== s3_key) errs++;
            if (w3_wr) errw++;
        end
        chk("stall_stable", errs, 0);
        chk("stall_wready", errw, 0);
        in_word_valid = 1'b0;
        complete_out();

        // Seed and word together at block start; zero seed acts as seed 1
        dsel = 2;
        do_reset();
        send_seed(80'hA5A5_5A5A_0F0F_F0F0_1234);
        @(posedge clk);
        #1 in_seed = 80'h0;
        in_seed_valid = 1'b1;
        in_word = vec[0].word;
        in_word_valid = 1'b1;
        @(negedge clk);
        chk("seed_prio", {sr(), wr()}, 2'b10);
        @(posedge clk);
        #1 in_seed_valid = 1'b0;
        send_block(12, 32'h0);
        chk("word_after_seed", first_wait, 1);
        wait_out("lat_seed0", 24);
        gen_q(80'h1);
        check_shares(12, 32'h0, 0, "seed0");
        complete_out();

        // Reset mid-block discards everything; rerun matches undisturbed run
        dsel = 2;
        do_reset();
        send_seed(SEED_A);
        send_block(8, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_pt", w2_pt, 0);
        chk("midrst_key", w2_key, 0);
        chk("midrst_ov", ov(), 0);
        chk("midrst_ready", {sr(), wr()}, 2'b10);
        send_seed(SEED_A);
        send_block(12, 32'h0);
        wait_out("lat_rerun", 24);
        chk("rerun_pt", w2_pt, snap_pt);
        chk("rerun_key", w2_key, snap_key);
        complete_out();

`ifdef SHARE_ENC_KEY_REUSE_EN
        // Plaintext-only block keeps previous key shares
        gen_q(SEED_A);
        snap_key = w2_key;
        in_key_reuse = 1'b1;
        send_block(4, 32'hdeadbeef);
        in_key_reuse = 1'b0;
        wait_out("lat_reuse", 8);
        chk("reuse_key", w2_key, snap_key);
        check_shares(4, 32'hdeadbeef, 12, "reuse");
        complete_out();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
